// File: rtl/airlight_pkg.sv
// airlight_pkg: shared state type, widths and helpers for the airlight frame controller
package airlight_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} state_t;
  localparam int PIX_W = 8;
  localparam int SUM_W = 10;
  localparam logic [PIX_W-1:0] INIT_A_DEF = 8'hFF;
  function automatic logic [SUM_W-1:0] rgb_sum(input logic [PIX_W-1:0] r, g, b);
    return SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
  endfunction
endpackage

// File: rtl/airlight_frame_ctrl_if.sv
// airlight_frame_ctrl_if: window handshake, estimator and committed-airlight signals
interface airlight_frame_ctrl_if;
  import airlight_pkg::*;
  logic start, win_valid, win_ready, est_en, a_valid, busy, frame_done;
  logic [PIX_W-1:0] est_r, est_g, est_b, a_r, a_g, a_b;
  modport master(
    output start, win_valid, est_r, est_g, est_b,
    input  win_ready, est_en, a_r, a_g, a_b, a_valid, busy, frame_done
  );
  modport slave(
    input  start, win_valid, est_r, est_g, est_b,
    output win_ready, est_en, a_r, a_g, a_b, a_valid, busy, frame_done
  );
endinterface

// File: rtl/airlight_max_sel.sv
// airlight_max_sel: keeps the brightest (largest r+g+b) estimator triple of a frame
module airlight_max_sel import airlight_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic [PIX_W-1:0] est_r,
  input  logic [PIX_W-1:0] est_g,
  input  logic [PIX_W-1:0] est_b,
  output logic [PIX_W-1:0] best_r,
  output logic [PIX_W-1:0] best_g,
  output logic [PIX_W-1:0] best_b
);
  logic             have_best;
  logic [SUM_W-1:0] best_sum, sum;
  assign sum = rgb_sum(est_r, est_g, est_b);
  // strict compare so that ties keep the earlier window
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      have_best <= 1'b0;
      best_sum  <= '0;
      best_r    <= '0;
      best_g    <= '0;
      best_b    <= '0;
    end else if (clear) begin
      have_best <= 1'b0;
      best_sum  <= '0;
    end else if (sample && (!have_best || sum > best_sum)) begin
      have_best <= 1'b1;
      best_sum  <= sum;
      best_r    <= est_r;
      best_g    <= est_g;
      best_b    <= est_b;
    end
endmodule

// File: rtl/airlight_frame_ctrl.sv
// airlight_frame_ctrl: frame sequencer for the airlight estimator; tracks the brightest
// result through a latency-matched tag pipe and commits it at frame end
module airlight_frame_ctrl import airlight_pkg::*; #(
  parameter int               IMG_W  = 640,
  parameter int               IMG_H  = 480,
  parameter int               LAT    = 4,
  parameter logic [PIX_W-1:0] INIT_A = INIT_A_DEF
)(
  input logic                 clk,
  input logic                 reset,
  airlight_frame_ctrl_if.slave bus
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [LAT-1:0]   tag;
  logic             accept, sample, clear;
  logic             a_valid, busy, frame_done;
  logic [PIX_W-1:0] best_r, best_g, best_b, a_r, a_g, a_b;
  assign bus.win_ready  = state == RUN;
  assign accept         = bus.win_valid && state == RUN;
  assign bus.est_en     = accept;
  assign sample         = tag[LAT-1];
  assign clear          = state == IDLE && bus.start;
  assign bus.a_r        = a_r;
  assign bus.a_g        = a_g;
  assign bus.a_b        = a_b;
  assign bus.a_valid    = a_valid;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  airlight_max_sel u_sel (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .sample(sample),
    .est_r (bus.est_r),
    .est_g (bus.est_g),
    .est_b (bus.est_b),
    .best_r(best_r),
    .best_g(best_g),
    .best_b(best_b)
  );
  // busy is updated alongside every state transition so it stays a flop output
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      tag        <= '0;
      a_r        <= INIT_A;
      a_g        <= INIT_A;
      a_b        <= INIT_A;
      a_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tag        <= LAT'({tag, accept});
      frame_done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          busy  <= 1'b1;
          col   <= '0;
          row   <= '0;
        end
        RUN: if (accept) begin
          col <= col == COL_LAST ? '0 : col + 1'b1;
          if (col == COL_LAST) begin
            row <= row == ROW_LAST ? '0 : row + 1'b1;
            if (row == ROW_LAST) state <= DRAIN;
          end
        end
        DRAIN: if (tag == '0) begin
          state      <= COMMIT;
          a_r        <= best_r;
          a_g        <= best_g;
          a_b        <= best_b;
          a_valid    <= 1'b1;
          frame_done <= 1'b1;
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule
